// File: rtl/bus_pkg.sv
// Shared bus definitions: ID width, broadcast ID and FIFO occupancy states.
package bus_pkg;

  localparam int BUS_ID_W = 8;
  localparam logic [BUS_ID_W-1:0] BROADCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/bus_tx_fifo_if.sv
// Host/arbiter-side handshake bundle of bus_tx_fifo.
// master: host write side plus arbiter pop side; slave: the FIFO itself.
interface bus_tx_fifo_if #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                  wr_en;
  logic [bus_pkg::BUS_ID_W-1:0]          wr_dest;
  logic [PCKG_SZ-bus_pkg::BUS_ID_W-1:0]  wr_payload;
  logic                                  wr_ready;
  logic                                  pop;
  logic                                  pndng;
  logic [PCKG_SZ-1:0]                    D_pop;
  logic [CNT_W-1:0]                      count;
  logic                                  ovf;

  modport master (
    output wr_en, wr_dest, wr_payload, pop,
    input  wr_ready, pndng, D_pop, count, ovf
  );

  modport slave (
    input  wr_en, wr_dest, wr_payload, pop,
    output wr_ready, pndng, D_pop, count, ovf
  );

endinterface

// File: rtl/bus_fifo_ram.sv
// Packet storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module bus_fifo_ram #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [PCKG_SZ-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [PCKG_SZ-1:0] rdata
);

  logic [PCKG_SZ-1:0] mem [DEPTH];

  // Store the incoming packet at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_tx_fifo.sv
// First-word-fall-through transmit FIFO placed in front of the bus arbiter.
// Packets are {dest, payload}; writes to a full FIFO are dropped and flagged
// via sticky ovf. Optional macro BUS_TX_FIFO_DROP_CNT_EN adds a saturating
// 16-bit drop_cnt output.
module bus_tx_fifo
  import bus_pkg::*;
#(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_tx_fifo_if.slave  bus
`ifdef BUS_TX_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fifo_state_e        state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               do_pop, do_wr, drop;
  logic [PCKG_SZ-1:0] rd_data;

  // A pop only counts when something is stored; a full FIFO still takes a
  // write if the head leaves in the same cycle.
  assign do_pop       = bus.pop && (state != EMPTY);
  assign bus.wr_ready = (cnt != CNT_FULL) || do_pop;
  assign do_wr        = bus.wr_en && bus.wr_ready;
  assign drop         = bus.wr_en && !bus.wr_ready;

  bus_fifo_ram #(
    .PCKG_SZ (PCKG_SZ),
    .DEPTH   (DEPTH),
    .ADDR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata ({bus.wr_dest, bus.wr_payload}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Next occupancy and occupancy state
  always_comb begin
    cnt_nxt = cnt;
    if (do_wr && !do_pop)      cnt_nxt = cnt + CNT_W'(1);
    else if (!do_wr && do_pop) cnt_nxt = cnt - CNT_W'(1);

    state_nxt = state;
    unique case (state)
      EMPTY:   if (do_wr) state_nxt = PARTIAL;
      PARTIAL: begin
        if (cnt_nxt == '0)            state_nxt = EMPTY;
        else if (cnt_nxt == CNT_FULL) state_nxt = FULL;
      end
      FULL:    if (do_pop && !do_wr) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  // Pointers, occupancy, state and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      state  <= EMPTY;
      bus.ovf <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      cnt   <= cnt_nxt;
      state <= state_nxt;
      if (drop) bus.ovf <= 1'b1;
    end
  end

`ifdef BUS_TX_FIFO_DROP_CNT_EN
  // Saturating count of dropped writes
  always_ff @(posedge clk) begin
    if (reset)                     drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  assign bus.pndng = (state != EMPTY);
  assign bus.count = cnt;
  assign bus.D_pop = bus.pndng ? rd_data : '0;

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Bench for bus_tx_fifo: DEPTH=8 and DEPTH=5 instances share one stimulus
// stream; a queue model per instance predicts every output.
module tb_bus_tx_fifo;

  localparam int PW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, pop;
  logic [7:0] wr_dest, wr_payload;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_tx_fifo_if #(.PCKG_SZ(PW), .DEPTH(8)) b8 ();
  bus_tx_fifo_if #(.PCKG_SZ(PW), .DEPTH(5)) b5 ();

  assign b8.wr_en = wr_en;  assign b8.wr_dest = wr_dest;
  assign b8.wr_payload = wr_payload;  assign b8.pop = pop;
  assign b5.wr_en = wr_en;  assign b5.wr_dest = wr_dest;
  assign b5.wr_payload = wr_payload;  assign b5.pop = pop;

`ifdef BUS_TX_FIFO_DROP_CNT_EN
  logic [15:0] dc8, dc5;
`endif

  bus_tx_fifo #(.PCKG_SZ(PW), .DEPTH(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
`ifdef BUS_TX_FIFO_DROP_CNT_EN
    , .drop_cnt (dc8)
`endif
  );

  bus_tx_fifo #(.PCKG_SZ(PW), .DEPTH(5)) u5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b5)
`ifdef BUS_TX_FIFO_DROP_CNT_EN
    , .drop_cnt (dc5)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected contents as plain queues
  logic [15:0] q8[$], q5[$];
  bit ovf8, ovf5, ep8, ep5, acc8, acc5;
  int drop8, drop5;

  always @(posedge clk) begin
    if (reset) begin
      q8.delete(); ovf8 = 0; drop8 = 0;
      q5.delete(); ovf5 = 0; drop5 = 0;
    end else begin
      ep8  = pop && (q8.size() > 0);
      acc8 = wr_en && ((q8.size() < 8) || ep8);
      if (ep8)  void'(q8.pop_front());
      if (acc8) q8.push_back({wr_dest, wr_payload});
      if (wr_en && !acc8) begin ovf8 = 1; if (drop8 < 65535) drop8++; end

      ep5  = pop && (q5.size() > 0);
      acc5 = wr_en && ((q5.size() < 5) || ep5);
      if (ep5)  void'(q5.pop_front());
      if (acc5) q5.push_back({wr_dest, wr_payload});
      if (wr_en && !acc5) begin ovf5 = 1; if (drop5 < 65535) drop5++; end
    end
  end

  // Monitor: compare presented outputs against the model away from the edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("count8", 32'(b8.count), q8.size());
      check("pndng8", 32'(b8.pndng), 32'(q8.size() != 0));
      check("dpop8",  32'(b8.D_pop), (q8.size() > 0) ? 32'(q8[0]) : 32'h0);
      check("wrrdy8", 32'(b8.wr_ready), 32'((q8.size() < 8) || (pop && q8.size() > 0)));
      check("ovf8",   32'(b8.ovf), 32'(ovf8));
      check("count5", 32'(b5.count), q5.size());
      check("pndng5", 32'(b5.pndng), 32'(q5.size() != 0));
      check("dpop5",  32'(b5.D_pop), (q5.size() > 0) ? 32'(q5[0]) : 32'h0);
      check("wrrdy5", 32'(b5.wr_ready), 32'((q5.size() < 5) || (pop && q5.size() > 0)));
      check("ovf5",   32'(b5.ovf), 32'(ovf5));
`ifdef BUS_TX_FIFO_DROP_CNT_EN
      check("dcnt8", 32'(dc8), drop8);
      check("dcnt5", 32'(dc5), drop5);
`endif
    end
  end

  task automatic cyc(input bit we, input logic [7:0] d, input logic [7:0] p, input bit pp);
    wr_en = we; wr_dest = d; wr_payload = p; pop = pp;
    @(posedge clk); #1;
  endtask

  // Reset with a write and pop pending, both of which must be ignored
  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 8'hEE, 8'hEE, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0; wr_dest = '0; wr_payload = '0;
    do_reset();
    mon_en = 1'b1;
    check("rst_count", 32'(b8.count), 0);
    check("rst_pndng", 32'(b8.pndng), 0);
    check("rst_dpop",  32'(b8.D_pop), 0);
    check("rst_ovf",   32'(b8.ovf), 0);

    cyc(1'b1, 8'h02, 8'hA5, 1'b0);
    check("first_pndng", 32'(b8.pndng), 1);
    check("first_dpop",  32'(b8.D_pop), 32'h02A5);
    check("first_count", 32'(b8.count), 1);

    for (int i = 1; i < 8; i++) cyc(1'b1, 8'(i), 8'(8'h10 + i), 1'b0);
    check("full_count", 32'(b8.count), 8);
    check("full_wrrdy", 32'(b8.wr_ready), 0);
    cyc(1'b1, 8'h99, 8'h99, 1'b0);
    check("drop_count", 32'(b8.count), 8);
    check("drop_ovf",   32'(b8.ovf), 1);
    check("drop_head",  32'(b8.D_pop), 32'h02A5);

    cyc(1'b1, 8'h77, 8'h01, 1'b1);
    check("wrpop_count", 32'(b8.count), 8);
    check("wrpop_head",  32'(b8.D_pop), 32'h0111);

    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1);
    check("drain_count", 32'(b8.count), 0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    check("emptypop_count", 32'(b8.count), 0);
    check("emptypop_pndng", 32'(b8.pndng), 0);
    check("emptypop_dpop",  32'(b8.D_pop), 0);
    cyc(1'b1, 8'h33, 8'h44, 1'b1);
    check("emptywp_count", 32'(b8.count), 1);
    check("emptywp_dpop",  32'(b8.D_pop), 32'h3344);

    // Write/pop pairs walk the DEPTH=5 pointers around the wrap several times
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h40 + i), 8'($urandom), 1'b1);
    cyc(1'b1, 8'h50, 8'h01, 1'b0);
    cyc(1'b1, 8'h51, 8'h02, 1'b0);
    check("wrap_count5", 32'(b5.count), 3);
    check("wrap_ovf5",   32'(b5.ovf), 1);
    do_reset();
    check("midrst_count5", 32'(b5.count), 0);
    check("midrst_ovf5",   32'(b5.ovf), 0);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom), $urandom_range(0, 99) < 50);
    end
    reset = 1'b0;

`ifdef BUS_TX_FIFO_DROP_CNT_EN
    do_reset();
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(i), 8'(i), 1'b0);
    check("dcnt_three", 32'(dc8), 3);
    for (int i = 0; i < 65540; i++) cyc(1'b1, 8'hAB, 8'hCD, 1'b0);
    check("dcnt_sat", 32'(dc8), 32'hFFFF);
`endif

    cyc(1'b0, 8'h00, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_tx_fifo.md
BUS_TX_FIFO -- requirements
Module: bus_tx_fifo

Interface
REQ-001 SHALL have parameter PCKG_SZ, default 16, total packet width in bits (ID field plus payload).
REQ-002 SHALL have parameter DEPTH, default 8, number of packet entries; legal range 2..256, any integer.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host write request.
REQ-006 SHALL have port wr_dest  input  8  destination ID; 8'hFF means broadcast.
REQ-007 SHALL have port wr_payload  input  PCKG_SZ-8  packet payload.
REQ-008 SHALL have port wr_ready  output  1  high when a write this cycle is accepted.
REQ-009 SHALL have port pop  input  1  arbiter consume strobe for the head packet.
REQ-010 SHALL have port pndng  output  1  high when at least one packet is stored.
REQ-011 SHALL have port D_pop  output  PCKG_SZ  head packet {dest, payload}; 0 when empty.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of stored packets.
REQ-013 SHALL have port ovf  output  1  sticky flag; a write was dropped.

Function
REQ-014 SHALL store packets as {wr_dest, wr_payload}, with dest in bits [PCKG_SZ-1:PCKG_SZ-8].
REQ-015 SHALL present the head packet first-word-fall-through: D_pop is valid whenever pndng=1, with no pop-to-data latency.
REQ-016 SHALL make an accepted write visible on pndng/count/D_pop (if FIFO was empty) one cycle after the write edge.
REQ-017 SHALL take an effective pop only when pop=1 and pndng=1; a pop while empty is ignored, with no state change.
REQ-018 SHALL accept a write when count<DEPTH, or when count==DEPTH and an effective pop occurs in the same cycle.
REQ-019 SHALL drive wr_ready combinationally per REQ-018.
REQ-020 SHALL, on wr_en=1 with wr_ready=0, drop the packet, leave the contents unchanged, and set ovf to 1 until reset.
REQ-021 SHALL, on a simultaneous accepted write and effective pop, keep count unchanged and advance both pointers.
REQ-022 SHALL, on a simultaneous write and pop while empty, accept the write and ignore the pop.
REQ-023 SHALL wrap the read and write pointers from DEPTH-1 to 0, for any DEPTH, not only powers of two.
REQ-024 SHALL implement state machine EMPTY/PARTIAL/FULL:
 - EMPTY→PARTIAL on a write (or FULL if DEPTH==1 is excluded);
 - PARTIAL→EMPTY when count becomes 0;
 - PARTIAL→FULL when count becomes DEPTH;
 - FULL→PARTIAL on a pop without a write;
 - otherwise the state holds.
REQ-025 SHALL derive pndng = (state != EMPTY) and count consistent with the state at all times.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear the pointers, set count=0, state=EMPTY, pndng=0, D_pop=0 and ovf=0.
REQ-027 SHALL, on a reset mid-operation, discard all stored packets; a wr_en or pop in the same cycle as reset is ignored.
REQ-028 SHALL leave storage array contents unreset; only the pointers and flags are reset.

Configuration
REQ-029 SHALL, with BUS_TX_FIFO_DROP_CNT_EN defined, add output drop_cnt (16 bits) counting dropped writes, saturating at 16'hFFFF and cleared by reset.
REQ-030 SHALL, without BUS_TX_FIFO_DROP_CNT_EN, omit the drop_cnt port and its logic entirely; ovf is present in both builds.

Structure
REQ-031 SHALL take from shared package bus_pkg: BUS_ID_W=8, BROADCAST_ID=8'hFF, and the fifo_state_e enum {EMPTY, PARTIAL, FULL}.
REQ-032 SHALL place storage in sub-module bus_fifo_ram (1 write port, 1 asynchronous read port, DEPTH x PCKG_SZ).
REQ-033 SHALL instantiate one bus_tx_fifo per driver in front of bs_gnrtr_n_rbtr, driving its pndng/D_pop lanes and consuming its pop lane.

Verification
REQ-034 SHALL cover: reset, then write dest=8'h02 payload=8'hA5 → next cycle pndng=1, D_pop=16'h02A5, count=1.
REQ-035 SHALL cover: 8 writes (DEPTH=8) → wr_ready=0, state FULL; 9th write → dropped, ovf=1, count=8, head unchanged.
REQ-036 SHALL cover: FULL with write and pop in the same cycle → write accepted, count stays 8, next head is the 2nd packet.
REQ-037 SHALL cover: pop while empty → count=0, pndng=0, D_pop=0; simultaneous write and pop while empty → count=1.
REQ-038 SHALL cover: DEPTH=5, 12 write/pop pairs → packets exit in order across the pointer wrap; then reset at count=3 → count=0, ovf=0 next cycle.
REQ-039 SHALL cover: with BUS_TX_FIFO_DROP_CNT_EN, 3 drops → drop_cnt=3, and drop_cnt saturates at 16'hFFFF under continuous overflow.
